// File: rtl/rename_pkg.sv
// Rename-stage shared definitions: physical register file geometry and tag types
// used by the free list, rename table and ROB.
package rename_pkg;
   localparam int NUM_PHYS_REGS = 64;
   localparam int NUM_ARCH_REGS = 32;
   localparam int LOG_PHYS      = $clog2(NUM_PHYS_REGS);

   typedef logic [LOG_PHYS-1:0] phys_tag_t;
   // One extra bit so a full queue (tail-head == NUM_PHYS_REGS) differs from empty.
   typedef logic [LOG_PHYS:0]   phys_ptr_t;
endpackage

// File: rtl/free_list_lane_offset.sv
// Prefix popcount: each lane gets the number of valid lanes below it, plus
// the total number of valid lanes.
module free_list_lane_offset #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0]       valid,
   output logic [WIDTH*CNT_W-1:0] offset,
   output logic [CNT_W-1:0]       total
);

   logic [CNT_W-1:0] acc;

   always_comb begin
      acc    = '0;
      offset = '0;
      for (int i = 0; i < WIDTH; i++) begin
         offset[i*CNT_W +: CNT_W] = acc;
         acc = acc + CNT_W'(valid[i]);
      end
      total = acc;
   end

endmodule

// File: rtl/free_list_superscalar.sv
// Multi-port physical register free list: DEQ_WIDTH allocations and ENQ_WIDTH
// frees per cycle, with head-pointer checkpoints for single-cycle mispredict recovery.
module free_list_superscalar
   import rename_pkg::*;
#(
   parameter  int DEQ_WIDTH = 4,
   parameter  int ENQ_WIDTH = 4,
   parameter  int NUM_CKPT  = 8,
   localparam int LOG_CKPT  = $clog2(NUM_CKPT)
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic [ENQ_WIDTH-1:0]          Enqueue_IN,
   input  logic [ENQ_WIDTH*LOG_PHYS-1:0] Data_IN,
   input  logic [DEQ_WIDTH-1:0]          Dequeue_IN,
   output logic                          DequeueResult_OUT,
   output logic [DEQ_WIDTH*LOG_PHYS-1:0] Data_OUT,
   output logic [LOG_PHYS:0]             FreeCount_OUT,
   input  logic                          Checkpoint_IN,
   input  logic [LOG_CKPT-1:0]           CheckpointTag_IN,
   input  logic                          Restore_IN,
   input  logic [LOG_CKPT-1:0]           RestoreTag_IN,
   output logic                          Overflow_OUT
);

   localparam int PTR_W  = LOG_PHYS + 1;
   localparam int DCNT_W = $clog2(DEQ_WIDTH + 1);
   localparam int ECNT_W = $clog2(ENQ_WIDTH + 1);

   phys_tag_t queue_q [NUM_PHYS_REGS];
   phys_ptr_t ckpt_q  [NUM_CKPT];
   phys_ptr_t head_q, tail_q, cnt_q;
   logic      ovf_q;

   logic [DEQ_WIDTH*DCNT_W-1:0] deq_off;
   logic [DCNT_W-1:0]           deq_tot;
   logic [ENQ_WIDTH*ECNT_W-1:0] enq_off;
   logic [ECNT_W-1:0]           enq_tot;

   logic      grant;
   phys_ptr_t head_nxt, tail_nxt, cnt_after_deq, space, enq_acc;
   logic      ovf_now;
   phys_tag_t rd_idx [DEQ_WIDTH];
   phys_tag_t wr_idx [ENQ_WIDTH];
   logic [ENQ_WIDTH-1:0] wr_en;

   free_list_lane_offset #(.WIDTH(DEQ_WIDTH), .CNT_W(DCNT_W)) u_deq_off (
      .valid  (Dequeue_IN),
      .offset (deq_off),
      .total  (deq_tot)
   );

   free_list_lane_offset #(.WIDTH(ENQ_WIDTH), .CNT_W(ECNT_W)) u_enq_off (
      .valid  (Enqueue_IN),
      .offset (enq_off),
      .total  (enq_tot)
   );

   // All-or-nothing grant; a restore squashes this cycle's allocation entirely.
   assign grant = !Restore_IN && (deq_tot != '0) && (cnt_q >= PTR_W'(deq_tot));
   assign DequeueResult_OUT = grant;

   always_comb begin
      Data_OUT = '0;
      for (int k = 0; k < DEQ_WIDTH; k++) begin
         rd_idx[k] = head_q[LOG_PHYS-1:0] + LOG_PHYS'(deq_off[k*DCNT_W +: DCNT_W]);
         if (grant && Dequeue_IN[k])
            Data_OUT[k*LOG_PHYS +: LOG_PHYS] = queue_q[rd_idx[k]];
      end
   end

   always_comb begin
      if (Restore_IN)
         head_nxt = ckpt_q[RestoreTag_IN];
      else if (grant)
         head_nxt = head_q + PTR_W'(deq_tot);
      else
         head_nxt = head_q;
   end

   // Enqueue capacity is judged against the head after dequeue/restore.
   assign cnt_after_deq = tail_q - head_nxt;
   assign space         = PTR_W'(NUM_PHYS_REGS) - cnt_after_deq;
   assign ovf_now       = PTR_W'(enq_tot) > space;
   assign enq_acc       = ovf_now ? space : PTR_W'(enq_tot);
   assign tail_nxt      = tail_q + enq_acc;

   always_comb begin
      for (int k = 0; k < ENQ_WIDTH; k++) begin
         wr_idx[k] = tail_q[LOG_PHYS-1:0] + LOG_PHYS'(enq_off[k*ECNT_W +: ECNT_W]);
         wr_en[k]  = Enqueue_IN[k] && (PTR_W'(enq_off[k*ECNT_W +: ECNT_W]) < space);
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < NUM_PHYS_REGS; i++)
            queue_q[i] <= (i < NUM_PHYS_REGS - NUM_ARCH_REGS) ? phys_tag_t'(NUM_ARCH_REGS + i) : '0;
         for (int c = 0; c < NUM_CKPT; c++)
            ckpt_q[c] <= '0;
         head_q <= '0;
         tail_q <= PTR_W'(NUM_PHYS_REGS - NUM_ARCH_REGS);
         cnt_q  <= PTR_W'(NUM_PHYS_REGS - NUM_ARCH_REGS);
         ovf_q  <= 1'b0;
      end else begin
         head_q <= head_nxt;
         tail_q <= tail_nxt;
         cnt_q  <= tail_nxt - head_nxt;
         if (ovf_now)
            ovf_q <= 1'b1;
         if (Checkpoint_IN)
            ckpt_q[CheckpointTag_IN] <= head_nxt;
         for (int k = 0; k < ENQ_WIDTH; k++)
            if (wr_en[k])
               queue_q[wr_idx[k]] <= Data_IN[k*LOG_PHYS +: LOG_PHYS];
      end
   end

   assign FreeCount_OUT = cnt_q;
   assign Overflow_OUT  = ovf_q;

endmodule

// File: tb/tb_free_list_superscalar.sv
// Directed and randomized checks of free_list_superscalar against a FIFO model
// built on unbounded integer head/tail indices.
module tb_free_list_superscalar;
   import rename_pkg::*;

   localparam int DW = 4;
   localparam int EW = 4;
   localparam int LP = LOG_PHYS;

   logic           CLK = 1'b0;
   logic           RESET;
   logic [EW-1:0]    Enqueue_IN;
   logic [EW*LP-1:0] Data_IN;
   logic [DW-1:0]    Dequeue_IN;
   logic             DequeueResult_OUT;
   logic [DW*LP-1:0] Data_OUT;
   logic [LP:0]      FreeCount_OUT;
   logic             Checkpoint_IN;
   logic [2:0]       CheckpointTag_IN;
   logic             Restore_IN;
   logic [2:0]       RestoreTag_IN;
   logic             Overflow_OUT;

   free_list_superscalar dut (
      .CLK               (CLK),
      .RESET             (RESET),
      .Enqueue_IN        (Enqueue_IN),
      .Data_IN           (Data_IN),
      .Dequeue_IN        (Dequeue_IN),
      .DequeueResult_OUT (DequeueResult_OUT),
      .Data_OUT          (Data_OUT),
      .FreeCount_OUT     (FreeCount_OUT),
      .Checkpoint_IN     (Checkpoint_IN),
      .CheckpointTag_IN  (CheckpointTag_IN),
      .Restore_IN        (Restore_IN),
      .RestoreTag_IN     (RestoreTag_IN),
      .Overflow_OUT      (Overflow_OUT)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model: free tags live in mem[idx % 64] between integer head and tail.
   int mem [64];
   int head, tail;
   int ckpt [8];
   bit ovf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] pk(input int a, input int b, input int c, input int d);
      return {6'(d), 6'(c), 6'(b), 6'(a)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) mem[i] = (i < 32) ? 32 + i : 0;
      for (int c = 0; c < 8; c++) ckpt[c] = 0;
      head = 0;
      tail = 32;
      ovf  = 1'b0;
   endtask

   task automatic idle();
      Enqueue_IN = '0; Data_IN = '0; Dequeue_IN = '0;
      Checkpoint_IN = 1'b0; CheckpointTag_IN = '0;
      Restore_IN = 1'b0; RestoreTag_IN = '0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      idle();
      RESET = 1'b0;
      #1;
      check("rst.count", 32'(FreeCount_OUT), 32);
      check("rst.ovf", 32'(Overflow_OUT), 0);
      model_reset();
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   task automatic step(input string tag, input logic [3:0] deq, input logic [3:0] enq,
                       input logic [23:0] dat, input bit ck, input int ct,
                       input bit rs, input int rt,
                       input bit xchk, input logic xg, input logic [23:0] xd);
      int r, cnt, j, nh, acc, space;
      bit g;
      logic [23:0] ed;
      @(negedge CLK);
      Dequeue_IN = deq; Enqueue_IN = enq; Data_IN = dat;
      Checkpoint_IN = ck; CheckpointTag_IN = 3'(ct);
      Restore_IN = rs; RestoreTag_IN = 3'(rt);
      #1;
      r   = $countones(deq);
      cnt = tail - head;
      g   = !rs && r != 0 && cnt >= r;
      ed  = '0;
      j   = 0;
      for (int k = 0; k < 4; k++)
         if (g && deq[k]) begin
            ed[k*6 +: 6] = 6'(mem[(head + j) % 64]);
            j++;
         end
      check({tag, ".res"}, 32'(DequeueResult_OUT), 32'(g));
      check({tag, ".data"}, 32'(Data_OUT), 32'(ed));
      if (xchk) begin
         check({tag, ".xres"}, 32'(DequeueResult_OUT), 32'(xg));
         check({tag, ".xdata"}, 32'(Data_OUT), 32'(xd));
      end
      nh    = rs ? ckpt[rt] : (g ? head + r : head);
      space = 64 - (tail - nh);
      acc   = 0;
      for (int k = 0; k < 4; k++)
         if (enq[k]) begin
            if (acc < space) begin
               mem[(tail + acc) % 64] = int'(dat[k*6 +: 6]);
               acc++;
            end else
               ovf = 1'b1;
         end
      tail += acc;
      if (ck) ckpt[ct] = nh;
      head = nh;
      @(posedge CLK);
      #1;
      check({tag, ".count"}, 32'(FreeCount_OUT), 32'(tail - head));
      check({tag, ".ovf"}, 32'(Overflow_OUT), 32'(ovf));
   endtask

   initial begin
      logic [23:0] d;
      int rt;
      bit rs;
      RESET = 1'b1;
      idle();

      // 1: four-wide allocation straight out of reset
      do_reset();
      step("t1", 4'b1111, 4'b0, '0, 0, 0, 0, 0, 1, 1'b1, pk(32, 33, 34, 35));
      check("t1.fc", 32'(FreeCount_OUT), 28);

      // 2: sparse request lanes
      do_reset();
      step("t2", 4'b1010, 4'b0, '0, 0, 0, 0, 0, 1, 1'b1, pk(0, 32, 0, 33));
      check("t2.fc", 32'(FreeCount_OUT), 30);

      // 3: insufficient entries, no bypass from same-cycle enqueue
      do_reset();
      for (int i = 0; i < 7; i++) step("t3.drain", 4'b1111, 4'b0, '0, 0, 0, 0, 0, 0, 1'b0, '0);
      step("t3.two", 4'b0011, 4'b0, '0, 0, 0, 0, 0, 0, 1'b0, '0);
      check("t3.fc2", 32'(FreeCount_OUT), 2);
      step("t3.fail", 4'b0111, 4'b0, '0, 0, 0, 0, 0, 1, 1'b0, '0);
      check("t3.fc_hold", 32'(FreeCount_OUT), 2);
      step("t3.nobyp", 4'b0111, 4'b0001, pk(5, 0, 0, 0), 0, 0, 0, 0, 1, 1'b0, '0);
      check("t3.fc3", 32'(FreeCount_OUT), 3);

      // 4: checkpoint, speculative allocation, restore
      do_reset();
      step("t4.ck", 4'b0, 4'b0, '0, 1, 3, 0, 0, 0, 1'b0, '0);
      step("t4.a", 4'b1111, 4'b0, '0, 0, 0, 0, 0, 0, 1'b0, '0);
      step("t4.b", 4'b1111, 4'b0, '0, 0, 0, 0, 0, 0, 1'b0, '0);
      check("t4.fc24", 32'(FreeCount_OUT), 24);
      step("t4.rs", 4'b1111, 4'b0, '0, 0, 0, 1, 3, 1, 1'b0, '0);
      check("t4.fc32", 32'(FreeCount_OUT), 32);
      step("t4.after", 4'b0001, 4'b0, '0, 0, 0, 0, 0, 1, 1'b1, pk(32, 0, 0, 0));

      // 5: steady allocate/free across several wraps
      do_reset();
      for (int i = 0; i < 40; i++) begin
         d = pk(mem[head % 64], mem[(head + 1) % 64], mem[(head + 2) % 64], mem[(head + 3) % 64]);
         step("t5", 4'b1111, 4'b1111, d, 0, 0, 0, 0, 0, 1'b0, '0);
      end
      check("t5.fc", 32'(FreeCount_OUT), 32);
      check("t5.ovf", 32'(Overflow_OUT), 0);

      // 6: fill to capacity, overflow, then asynchronous reset mid-cycle
      do_reset();
      for (int i = 0; i < 7; i++) step("t6.fill", 4'b0, 4'b1111, 24'($urandom), 0, 0, 0, 0, 0, 1'b0, '0);
      step("t6.63", 4'b0, 4'b0111, 24'($urandom), 0, 0, 0, 0, 0, 1'b0, '0);
      check("t6.fc63", 32'(FreeCount_OUT), 63);
      step("t6.ovf", 4'b0, 4'b0011, pk(7, 9, 0, 0), 0, 0, 0, 0, 0, 1'b0, '0);
      check("t6.fc64", 32'(FreeCount_OUT), 64);
      check("t6.ovf1", 32'(Overflow_OUT), 1);
      step("t6.sticky", 4'b0, 4'b0, '0, 0, 0, 0, 0, 0, 1'b0, '0);
      check("t6.ovf_hold", 32'(Overflow_OUT), 1);
      @(posedge CLK);
      #3;
      idle();
      Dequeue_IN = 4'b1111;
      RESET = 1'b0;
      #1;
      check("t6.rst_fc", 32'(FreeCount_OUT), 32);
      check("t6.rst_ovf", 32'(Overflow_OUT), 0);
      check("t6.rst_res", 32'(DequeueResult_OUT), 1);
      check("t6.rst_data", 32'(Data_OUT), 32'(pk(32, 33, 34, 35)));
      model_reset();
      @(negedge CLK);
      idle();
      RESET = 1'b1;

      // Randomized traffic with occasional checkpoints and legal restores
      for (int i = 0; i < 400; i++) begin
         rt = int'($urandom_range(0, 7));
         rs = ($urandom_range(0, 9) == 0) && (tail - ckpt[rt] <= 64);
         step("rnd", 4'($urandom), 4'($urandom) & 4'($urandom), 24'($urandom),
              $urandom_range(0, 5) == 0, int'($urandom_range(0, 7)), rs, rt, 0, 1'b0, '0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
